cdb_broadcaster: RTL and testbench

//  Drives the common data bus (CDB) seen by every reservation station and the register file.

---
 rtl/cdb_broadcaster_if.sv | 28 ++
 rtl/cdb_broadcaster.sv | 109 ++++++++++
 tb/tb_cdb_broadcaster.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cdb_broadcaster_if.sv
// Bundle of request, acknowledge and broadcast signals between the CDB broadcaster,
// the functional-unit requesters and the snooping stations/register file.
interface cdb_broadcaster_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int LW = 4,
    parameter int CW = 16
);
    logic [N-1:0]    require;
    logic [N*DW-1:0] dataIn;
    logic [N*LW-1:0] labelIn;
    logic [N-1:0]    requireAC;
    logic            BCEN;
    logic [LW-1:0]   BClabel;
    logic [DW-1:0]   BCdata;
    logic            badLabel;
    logic [CW-1:0]   bcCount;

    // master: the broadcaster itself; slave: requesters and snoopers.
    modport master (
        input  require, dataIn, labelIn,
        output requireAC, BCEN, BClabel, BCdata, badLabel, bcCount
    );
    modport slave (
        output require, dataIn, labelIn,
        input  requireAC, BCEN, BClabel, BCdata, badLabel, bcCount
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Round-robin arbiter that grants one functional-unit result per cycle and
// broadcasts the winner's tag/data on the common data bus one cycle later.
module cdb_broadcaster #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int LW = 4,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    cdb_broadcaster_if.master    bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] data_arr  [N];
    logic [LW-1:0] label_arr [N];

    logic [PW-1:0] ptr_q, ptr_d;
    logic          bcen_q, bcen_d;
    logic          bad_q, bad_d;
    logic [LW-1:0] label_q, label_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] count_q, count_d;

    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] scan_idx;
    logic [N-1:0]  grant_oh;
    logic [LW-1:0] win_label;
    logic [DW-1:0] win_data;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign data_arr[gi]  = bus.dataIn[gi*DW +: DW];
            assign label_arr[gi] = bus.labelIn[gi*LW +: LW];
        end
    endgenerate

    // Scan starting at the pointer; the first active requester wins.
    // Grants are suppressed during reset so no request is consumed then.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        grant_oh    = '0;
        if (!RST) begin
            for (int k = 0; k < N; k++) begin
                scan_idx = PW'((int'(ptr_q) + k) % N);
                if (!grant_valid && bus.require[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign win_label = label_arr[grant_idx];
    assign win_data  = data_arr[grant_idx];

    always_comb begin
        ptr_d   = ptr_q;
        bcen_d  = 1'b0;
        bad_d   = 1'b0;
        label_d = label_q;
        data_d  = data_q;
        count_d = count_q;
        if (grant_valid) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + PW'(1);
            // Label 0 means "no producer": consume the request but do not broadcast.
            if (win_label != '0) begin
                bcen_d  = 1'b1;
                label_d = win_label;
                data_d  = win_data;
                count_d = count_q + CW'(1);
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            ptr_q   <= '0;
            bcen_q  <= 1'b0;
            bad_q   <= 1'b0;
            label_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            bcen_q  <= bcen_d;
            bad_q   <= bad_d;
            label_q <= label_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign bus.requireAC = grant_oh;
    assign bus.BCEN      = bcen_q;
    assign bus.BClabel   = label_q;
    assign bus.BCdata    = data_q;
    assign bus.badLabel  = bad_q;
    assign bus.bcCount   = count_q;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, single grant, contention order,
// fairness, label-0 requests, reset mid-flight and counter wrap (CW=8).
module tb_cdb_broadcaster;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int CW = 8;

    logic clk;
    logic RST;
    logic [LW-1:0] lab [N];
    logic [DW-1:0] dat [N];

    int total;
    int passed;

    cdb_broadcaster_if #(.N(N), .DW(DW), .LW(LW), .CW(CW)) bus ();

    cdb_broadcaster #(.N(N), .DW(DW), .LW(LW), .CW(CW)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.labelIn = '0;
        bus.dataIn  = '0;
        for (int i = 0; i < N; i++) begin
            bus.labelIn[i*LW +: LW] = lab[i];
            bus.dataIn[i*DW +: DW]  = dat[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < N; i++) begin
            lab[i] = LW'(i + 1);
            dat[i] = 32'h1000_0000 + 32'(i);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        set_defaults();
        RST         = 1'b1;
        bus.require = 4'b1111;

        // T1: reset held two cycles with everything requesting
        chk("t1_ack_pre", 64'(bus.requireAC), 64'h0);
        tick();
        chk("t1_ack_c1", 64'(bus.requireAC), 64'h0);
        tick();
        chk("t1_ack_c2", 64'(bus.requireAC), 64'h0);
        RST = 1'b0;
        #1;
        chk("t1_bcen", 64'(bus.BCEN), 64'h0);
        chk("t1_count", 64'(bus.bcCount), 64'h0);
        chk("t1_bad", 64'(bus.badLabel), 64'h0);

        // T3: contention from reset, order alu, mul, div, ls
        chk("t3_ack0", 64'(bus.requireAC), 64'h1);
        for (int g = 0; g < N; g++) begin
            tick();
            chk($sformatf("t3_bcen%0d", g), 64'(bus.BCEN), 64'h1);
            chk($sformatf("t3_label%0d", g), 64'(bus.BClabel), 64'(g + 1));
            chk($sformatf("t3_data%0d", g), 64'(bus.BCdata), 64'(32'h1000_0000 + 32'(g)));
            chk($sformatf("t3_count%0d", g), 64'(bus.bcCount), 64'(g + 1));
            chk($sformatf("t3_ack%0d", g + 1), 64'(bus.requireAC), 64'(4'b0001 << ((g + 1) % N)));
        end
        bus.require = 4'b0000;
        #1;
        chk("idle_ack", 64'(bus.requireAC), 64'h0);
        tick();
        chk("idle_bcen", 64'(bus.BCEN), 64'h0);
        chk("idle_label_hold", 64'(bus.BClabel), 64'h4);
        chk("idle_count_hold", 64'(bus.bcCount), 64'h4);

        // T2: single request from div (ptr=0)
        lab[2] = 4'd5;
        dat[2] = 32'hDEAD_BEEF;
        bus.require = 4'b0100;
        #1;
        chk("t2_ack", 64'(bus.requireAC), 64'h4);
        tick();
        bus.require = 4'b0000;
        chk("t2_bcen", 64'(bus.BCEN), 64'h1);
        chk("t2_label", 64'(bus.BClabel), 64'h5);
        chk("t2_data", 64'(bus.BCdata), 64'hDEAD_BEEF);
        chk("t2_count", 64'(bus.bcCount), 64'h5);

        // T5: label-0 request from mul (ptr=3, scan wraps to 1)
        lab[1] = 4'd0;
        bus.require = 4'b0010;
        #1;
        chk("t5_ack", 64'(bus.requireAC), 64'h2);
        tick();
        bus.require = 4'b0000;
        chk("t5_bcen", 64'(bus.BCEN), 64'h0);
        chk("t5_bad", 64'(bus.badLabel), 64'h1);
        chk("t5_count", 64'(bus.bcCount), 64'h5);
        chk("t5_label", 64'(bus.BClabel), 64'h5);
        chk("t5_data", 64'(bus.BCdata), 64'hDEAD_BEEF);
        tick();
        chk("t5_bad_clear", 64'(bus.badLabel), 64'h0);
        set_defaults();

        // T4: bring ptr to 0 (grant ls), then alu re-requests while ls waits
        bus.require = 4'b1000;
        tick();
        chk("t4_pre_count", 64'(bus.bcCount), 64'h6);
        bus.require = 4'b1001;
        #1;
        chk("t4_ack_alu", 64'(bus.requireAC), 64'h1);
        tick();
        chk("t4_label_alu", 64'(bus.BClabel), 64'h1);
        chk("t4_ack_ls", 64'(bus.requireAC), 64'h8);
        tick();
        chk("t4_label_ls", 64'(bus.BClabel), 64'h4);
        chk("t4_count", 64'(bus.bcCount), 64'h8);
        chk("t4_ack_alu2", 64'(bus.requireAC), 64'h1);
        bus.require = 4'b0000;
        tick();

        // T6: grant mul (label 3), then reset on the following edge
        lab[1] = 4'd3;
        bus.require = 4'b0010;
        #1;
        chk("t6_ack_mul", 64'(bus.requireAC), 64'h2);
        tick();
        chk("t6_bcen_k", 64'(bus.BCEN), 64'h1);
        chk("t6_label_k", 64'(bus.BClabel), 64'h3);
        RST = 1'b1;
        #1;
        chk("t6_ack_in_rst", 64'(bus.requireAC), 64'h0);
        tick();
        RST = 1'b0;
        bus.require = 4'b0000;
        chk("t6_bcen_k1", 64'(bus.BCEN), 64'h0);
        chk("t6_count", 64'(bus.bcCount), 64'h0);
        bus.require = 4'b0011;
        #1;
        chk("t6_ack_alu", 64'(bus.requireAC), 64'h1);
        bus.require = 4'b0110;
        #1;
        chk("t6_ptr_zero", 64'(bus.requireAC), 64'h2);
        bus.require = 4'b0000;
        tick();
        set_defaults();

        // T7: 2^CW broadcasts from alu wrap bcCount to 0
        bus.require = 4'b0001;
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            tick();
        end
        chk("t7_count_max", 64'(bus.bcCount), 64'hFF);
        tick();
        chk("t7_count_wrap", 64'(bus.bcCount), 64'h0);
        chk("t7_bcen", 64'(bus.BCEN), 64'h1);
        bus.require = 4'b1111;
        #1;
        chk("t7_ack_after", 64'(bus.requireAC), 64'h2);
        tick();
        bus.require = 4'b0000;
        chk("t7_label_after", 64'(bus.BClabel), 64'h2);
        chk("t7_count_after", 64'(bus.bcCount), 64'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
